// File: rtl/cache_dummy_pkg.sv
// Shared definitions for the dummy data cache: word width, default access latency
// and the access FSM state encoding.
package cache_dummy_pkg;

  localparam int WORD_W          = 32;
  localparam int DEFAULT_LATENCY = 2;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/cache_dummy_mem.sv
// Single-port word RAM with synchronous write and registered synchronous read.
// The contents have no reset and rely on the power-up value of the array.
module cache_dummy_mem
  import cache_dummy_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  word_t                 wdata,
  output word_t                 rdata
);

  word_t mem_reg [2**DEPTH_LOG2];
  word_t rdata_reg;

  // The read register only loads on read cycles, so it keeps its value between accesses.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_reg[addr] <= wdata;
      end else begin
        rdata_reg <= mem_reg[addr];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/cache_dummy_top.sv
// Dummy data cache: fixed-latency access FSM in front of a word RAM, with a
// combinational ready signal that is high only when dout matches the current address.
module cache_dummy_top
  import cache_dummy_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic        rdy,
  output logic [31:0] dout
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [0:0]            state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DEPTH_LOG2-1:0] lat_idx_reg;
  logic [DEPTH_LOG2-1:0] last_idx_reg;
  logic                  lat_we_reg;
  word_t                 lat_din_reg;
  logic                  valid_reg;
  word_t                 dout_reg;
  logic                  rd_sel_reg;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  start;
  logic                  done;
  word_t                 ram_rdata;
  logic                  unused_addr_bits;

  assign req_idx          = addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  assign start = (state_reg == IDLE) && (we || !valid_reg || (req_idx != last_idx_reg));
  assign done  = (state_reg == ACCESS) && (cnt_reg == '0);
  assign rdy   = (state_reg == IDLE) && valid_reg && !we && (req_idx == last_idx_reg);

  // Reads land in the RAM's own output register; writes and reset are served from dout_reg.
  assign dout = rd_sel_reg ? ram_rdata : dout_reg;

  cache_dummy_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .en   (done),
    .we   (lat_we_reg),
    .addr (lat_idx_reg),
    .wdata(lat_din_reg),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      lat_idx_reg  <= '0;
      last_idx_reg <= '0;
      lat_we_reg   <= 1'b0;
      lat_din_reg  <= '0;
      valid_reg    <= 1'b0;
      dout_reg     <= '0;
      rd_sel_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            lat_idx_reg <= req_idx;
            lat_we_reg  <= we;
            lat_din_reg <= din;
            cnt_reg     <= CNT_LOAD;
            state_reg   <= ACCESS;
          end
        end
        ACCESS: begin
          if (done) begin
            last_idx_reg <= lat_idx_reg;
            valid_reg    <= 1'b1;
            state_reg    <= IDLE;
            rd_sel_reg   <= !lat_we_reg;
            if (lat_we_reg) begin
              dout_reg <= lat_din_reg;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_dummy_top.sv
// Self-checking bench for cache_dummy_top: directed scenarios plus random traffic
// checked against a word-array model of memory and ready/latency behaviour.
module tb_cache_dummy_top;

  localparam int DL  = 8;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic        rdy;
  logic [31:0] dout;

  always #20 clk = ~clk;

  cache_dummy_top #(
    .DEPTH_LOG2(DL),
    .LATENCY   (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .addr(addr),
    .din (din),
    .rdy (rdy),
    .dout(dout)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: memory contents and which word dout currently holds.
  logic [31:0] ref_mem [2**DL];
  bit          ref_valid;
  int          ref_last;

  function automatic int widx(input logic [31:0] a);
    return int'(a[DL+1:2]);
  endfunction

  // Read: a hit is ready at once with no access; a miss takes start edge + LAT edges.
  task automatic do_read(input logic [31:0] a);
    bit          early;
    logic [31:0] exp;
    exp   = ref_mem[widx(a)];
    early = 1'b0;
    addr  = a;
    we    = 1'b0;
    #1;
    if (ref_valid && widx(a) == ref_last) begin
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (rdy !== 1'b1 || dout !== exp) begin
          tests_failed++;
          $display("FAIL read_hit addr=%h step=%0d rdy=%b dout=%h expected rdy=1 dout=%h",
                   a, i, rdy, dout, exp);
        end
        @(posedge clk); #2;
      end
      $display("[TB] read hit  addr=%h dout=%h", a, dout);
    end else begin
      if (rdy !== 1'b0) early = 1'b1;
      for (int i = 1; i <= LAT + 1; i++) begin
        @(posedge clk); #2;
        if (i <= LAT && rdy !== 1'b0) early = 1'b1;
      end
      tests_run++;
      if (early || rdy !== 1'b1 || dout !== exp) begin
        tests_failed++;
        $display("FAIL read_miss addr=%h early_rdy=%b rdy=%b dout=%h expected rdy=1 dout=%h",
                 a, early, rdy, dout, exp);
      end
      ref_valid = 1'b1;
      ref_last  = widx(a);
      $display("[TB] read miss addr=%h dout=%h", a, dout);
    end
  endtask

  // Write held for reps full accesses; rdy must stay low while we=1, then rise when we drops.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int reps);
    bit bad;
    bad  = 1'b0;
    addr = a;
    din  = d;
    we   = 1'b1;
    #1;
    if (rdy !== 1'b0) bad = 1'b1;
    for (int i = 1; i <= reps * (LAT + 1); i++) begin
      @(posedge clk); #2;
      if (rdy !== 1'b0) bad = 1'b1;
    end
    we = 1'b0;
    #1;
    ref_mem[widx(a)] = d;
    ref_valid        = 1'b1;
    ref_last         = widx(a);
    tests_run++;
    if (bad || rdy !== 1'b1 || dout !== d) begin
      tests_failed++;
      $display("FAIL write addr=%h rdy_high_while_we=%b rdy=%b dout=%h expected rdy=1 dout=%h",
               a, bad, rdy, dout, d);
    end
    $display("[TB] write     addr=%h din=%h reps=%0d", a, d, reps);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    we   = 1'b0;
    addr = 32'd0;
    din  = 32'd0;
    @(posedge clk); @(posedge clk); #2;
    tests_run++;
    if (rdy !== 1'b0 || dout !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state rdy=%b dout=%h expected rdy=0 dout=00000000", rdy, dout);
    end
    rst       = 1'b0;
    ref_valid = 1'b0;
    #1;
    do_read(32'd0);
  endtask

  task automatic test_write_signed();
    do_write(32'd15, -32'sd7584, 1);
    tests_run++;
    if (dout !== 32'hFFFFE260) begin
      tests_failed++;
      $display("FAIL write_signed dout=%h expected FFFFE260", dout);
    end
  endtask

  task automatic test_same_word();
    do_read(32'd12);
    do_write(32'd56, 32'd9573, 1);
    do_read(32'd15);
  endtask

  task automatic test_reset_mid_access();
    addr = 32'd56;
    din  = 32'hDEADBEEF;
    we   = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (rdy !== 1'b0 || dout !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_mid_access step=%0d rdy=%b dout=%h expected rdy=0 dout=00000000",
                 i, rdy, dout);
      end
      @(posedge clk); #2;
    end
    rst       = 1'b0;
    ref_valid = 1'b0;
    #1;
    do_read(32'd56);
  endtask

  task automatic test_wrap();
    do_write(32'd8, 32'd7, 1);
    do_read(32'd4 * (32'd1 << DL) + 32'd8);
    tests_run++;
    if (dout !== 32'd7) begin
      tests_failed++;
      $display("FAIL index_wrap dout=%h expected 00000007", dout);
    end
  endtask

  // Address change while an access is in flight: first read finishes, then a second read runs.
  task automatic test_addr_change();
    logic [31:0] a;
    logic [31:0] b;
    bit          early;
    a     = 32'h0000_0100;
    b     = 32'h0000_0204;
    early = 1'b0;
    addr  = a;
    we    = 1'b0;
    @(posedge clk); #2;
    addr = b;
    for (int i = 2; i <= 2 * (LAT + 1); i++) begin
      @(posedge clk); #2;
      if (i < 2 * (LAT + 1) && rdy !== 1'b0) early = 1'b1;
    end
    tests_run++;
    if (early || rdy !== 1'b1 || dout !== ref_mem[widx(b)]) begin
      tests_failed++;
      $display("FAIL addr_change early_rdy=%b rdy=%b dout=%h expected rdy=1 dout=%h",
               early, rdy, dout, ref_mem[widx(b)]);
    end
    ref_valid = 1'b1;
    ref_last  = widx(b);
    $display("[TB] addr change a=%h b=%h dout=%h", a, b, dout);
  endtask

  task automatic test_back_to_back();
    do_write(32'h0000_0040, 32'h1234_5678, 3);
    do_read(32'h0000_0041);
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      r = $urandom();
      a = (r & ~32'h0000_03FC) | (32'($urandom_range(20, 25)) << 2);
      if ($urandom_range(0, 2) == 0) begin
        do_write(a, $urandom(), int'($urandom_range(1, 2)));
      end else begin
        do_read(a);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2**DL; i++) ref_mem[i] = 32'd0;
    ref_valid = 1'b0;
    ref_last  = 0;
    test_reset();
    test_write_signed();
    test_same_word();
    test_reset_mid_access();
    test_wrap();
    test_addr_change();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
